// File: rtl/pe_bus_arbiter_if.sv
// ============================================================================
// Module      : pe_bus_arbiter_if
// Description : Request/grant bundle between the PE bus arbiter and its users.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pe_bus_arbiter_if #(
   parameter int NUM_REQ = 8,
   parameter int ID_W    = 3
);
   logic               host_we;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_id;
   logic               host_ok;
   logic               bus_busy;
   logic [4:0]         word_cnt;

   modport master (
      input  host_we, req,
      output gnt, gnt_id, host_ok, bus_busy, word_cnt
   );

   modport slave (
      output host_we, req,
      input  gnt, gnt_id, host_ok, bus_busy, word_cnt
   );
endinterface

`default_nettype wire

// File: rtl/pe_bus_arbiter.sv
// ============================================================================
// Module      : pe_bus_arbiter
// Description : Host-priority, round-robin PE arbiter for the shared data bus
//               with capped bursts and dead cycles on every driver change.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_bus_arbiter #(
   parameter int NUM_REQ     = 8,
   parameter int ID_W        = 3,
   parameter int MAX_BURST   = 32,
   parameter int TURN_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   pe_bus_arbiter_if.master    bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOST  = 2'd1,
      GRANT = 2'd2,
      TURN  = 2'd3
   } state_t;

   localparam logic [4:0]      LAST_WORD = 5'(MAX_BURST - 1);
   localparam logic [1:0]      LAST_TURN = 2'(TURN_CYCLES - 1);
   localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

   state_t             state;
   logic [ID_W-1:0]    rr_ptr;
   logic [1:0]         turn_cnt;

   logic               pick_valid;
   logic [ID_W-1:0]    pick_id;
   logic [NUM_REQ-1:0] other_req;
   logic               release_grant;
   logic               dispatch;

   // Scan downward so the requester closest to rr_ptr overwrites the rest.
   always_comb begin
      logic [ID_W-1:0] idx;
      idx        = '0;
      pick_valid = 1'b0;
      pick_id    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (bus.req[idx]) begin
            pick_valid = 1'b1;
            pick_id    = idx;
         end
      end
   end

   assign other_req     = bus.req & ~(NUM_REQ'(1) << bus.gnt_id);
   assign release_grant = !bus.req[bus.gnt_id] || bus.host_we ||
                          ((bus.word_cnt == LAST_WORD) && (|other_req));
   assign dispatch      = (state == IDLE) ||
                          ((state == TURN) && (turn_cnt == LAST_TURN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         turn_cnt     <= '0;
         bus.gnt      <= '0;
         bus.gnt_id   <= '0;
         bus.host_ok  <= 1'b0;
         bus.bus_busy <= 1'b0;
         bus.word_cnt <= '0;
      end else if (dispatch) begin
         turn_cnt <= '0;
         if (bus.host_we) begin
            state        <= HOST;
            bus.host_ok  <= 1'b1;
            bus.bus_busy <= 1'b1;
         end else if (pick_valid) begin
            state        <= GRANT;
            bus.gnt      <= NUM_REQ'(1) << pick_id;
            bus.gnt_id   <= pick_id;
            bus.word_cnt <= '0;
            bus.bus_busy <= 1'b1;
         end else begin
            state        <= IDLE;
            bus.bus_busy <= 1'b0;
         end
      end else begin
         case (state)
            HOST: begin
               if (!bus.host_we) begin
                  state       <= TURN;
                  bus.host_ok <= 1'b0;
               end
            end
            GRANT: begin
               if (release_grant) begin
                  state   <= TURN;
                  bus.gnt <= '0;
                  rr_ptr  <= (bus.gnt_id == LAST_ID) ? '0 : bus.gnt_id + ID_W'(1);
               end else begin
                  // A lone requester keeps the bus; the burst counter just wraps.
                  bus.word_cnt <= (bus.word_cnt == LAST_WORD) ? 5'd0 : bus.word_cnt + 5'd1;
               end
            end
            TURN: begin
               turn_cnt <= turn_cnt + 2'd1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pe_bus_arbiter.sv
// ============================================================================
// Module      : tb_pe_bus_arbiter
// Description : Directed self-checking bench for pe_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_bus_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   pe_bus_arbiter_if #(.NUM_REQ(8), .ID_W(3)) bus32 ();
   pe_bus_arbiter_if #(.NUM_REQ(8), .ID_W(3)) bus4 ();

   pe_bus_arbiter #(.NUM_REQ(8), .ID_W(3), .MAX_BURST(32), .TURN_CYCLES(1)) dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus32)
   );

   pe_bus_arbiter #(.NUM_REQ(8), .ID_W(3), .MAX_BURST(4), .TURN_CYCLES(1)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   always #5 clk = ~clk;

   // Bus-safety invariants on both instances, sampled mid-cycle.
   always @(negedge clk) begin
      n_checks += 4;
      if (!$onehot0(bus32.gnt)) begin n_fail++; $display("FAIL onehot32: gnt=%h", bus32.gnt); end
      if ((bus32.gnt != 0) && bus32.host_ok) begin n_fail++; $display("FAIL overlap32: gnt=%h host_ok=%b required no overlap", bus32.gnt, bus32.host_ok); end
      if (!$onehot0(bus4.gnt)) begin n_fail++; $display("FAIL onehot4: gnt=%h", bus4.gnt); end
      if ((bus4.gnt != 0) && bus4.host_ok) begin n_fail++; $display("FAIL overlap4: gnt=%h host_ok=%b required no overlap", bus4.gnt, bus4.host_ok); end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus32.host_we = 1'b0; bus32.req = 8'h00;
      bus4.host_we  = 1'b0; bus4.req  = 8'h00;
      repeat (3) step();
      n_checks += 6;
      if (bus32.gnt !== 8'h00)     begin n_fail++; $display("FAIL reset_gnt: got %h want 00", bus32.gnt); end
      if (bus32.gnt_id !== 3'd0)   begin n_fail++; $display("FAIL reset_gnt_id: got %0d want 0", bus32.gnt_id); end
      if (bus32.host_ok !== 1'b0)  begin n_fail++; $display("FAIL reset_host_ok: got %b want 0", bus32.host_ok); end
      if (bus32.bus_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus32.bus_busy); end
      if (bus32.word_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_word_cnt: got %0d want 0", bus32.word_cnt); end
      if (bus4.gnt !== 8'h00)      begin n_fail++; $display("FAIL reset_gnt4: got %h want 00", bus4.gnt); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic_grant();
      bus32.req = 8'h01;
      step();
      n_checks += 5;
      if (bus32.gnt !== 8'h01)     begin n_fail++; $display("FAIL basic_gnt: got %h want 01", bus32.gnt); end
      if (bus32.gnt_id !== 3'd0)   begin n_fail++; $display("FAIL basic_gnt_id: got %0d want 0", bus32.gnt_id); end
      if (bus32.bus_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", bus32.bus_busy); end
      if (bus32.word_cnt !== 5'd0) begin n_fail++; $display("FAIL basic_word_cnt: got %0d want 0", bus32.word_cnt); end
      if (bus32.host_ok !== 1'b0)  begin n_fail++; $display("FAIL basic_host_ok: got %b want 0", bus32.host_ok); end
      bus32.req = 8'h00;
      step();
      n_checks += 2;
      if (bus32.gnt !== 8'h00)     begin n_fail++; $display("FAIL basic_turn_gnt: got %h want 00", bus32.gnt); end
      if (bus32.bus_busy !== 1'b1) begin n_fail++; $display("FAIL basic_turn_busy: got %b want 1", bus32.bus_busy); end
      step();
      n_checks += 3;
      if (bus32.bus_busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b want 0", bus32.bus_busy); end
      if (bus32.gnt !== 8'h00)     begin n_fail++; $display("FAIL basic_idle_gnt: got %h want 00", bus32.gnt); end
      if (bus32.gnt_id !== 3'd0)   begin n_fail++; $display("FAIL basic_idle_gnt_id: got %0d want 0", bus32.gnt_id); end
   endtask

   task automatic test_burst_rr();
      logic [7:0] exp_gnt;
      bus4.req = 8'h05;
      step();
      for (int r = 0; r < 4; r++) begin
         exp_gnt = (r % 2 == 0) ? 8'h01 : 8'h04;
         for (int c = 0; c < 4; c++) begin
            n_checks += 2;
            if (bus4.gnt !== exp_gnt) begin n_fail++; $display("FAIL burst_gnt r%0d c%0d: got %h want %h", r, c, bus4.gnt, exp_gnt); end
            if (bus4.word_cnt !== 5'(c)) begin n_fail++; $display("FAIL burst_word_cnt r%0d c%0d: got %0d want %0d", r, c, bus4.word_cnt, c); end
            step();
         end
         n_checks += 2;
         if (bus4.gnt !== 8'h00)     begin n_fail++; $display("FAIL burst_turn_gnt r%0d: got %h want 00", r, bus4.gnt); end
         if (bus4.bus_busy !== 1'b1) begin n_fail++; $display("FAIL burst_turn_busy r%0d: got %b want 1", r, bus4.bus_busy); end
         step();
      end
      n_checks += 1;
      if (bus4.gnt !== 8'h01) begin n_fail++; $display("FAIL burst_final_gnt: got %h want 01", bus4.gnt); end
      bus4.req = 8'h00;
      step();
      step();
      n_checks += 1;
      if (bus4.bus_busy !== 1'b0) begin n_fail++; $display("FAIL burst_idle_busy: got %b want 0", bus4.bus_busy); end
   endtask

   task automatic test_host_preempt();
      bus32.req = 8'h08;
      step();
      n_checks += 2;
      if (bus32.gnt !== 8'h08)   begin n_fail++; $display("FAIL preempt_gnt: got %h want 08", bus32.gnt); end
      if (bus32.gnt_id !== 3'd3) begin n_fail++; $display("FAIL preempt_gnt_id: got %0d want 3", bus32.gnt_id); end
      bus32.host_we = 1'b1;
      step();
      n_checks += 2;
      if (bus32.gnt !== 8'h00)    begin n_fail++; $display("FAIL preempt_turn_gnt: got %h want 00", bus32.gnt); end
      if (bus32.host_ok !== 1'b0) begin n_fail++; $display("FAIL preempt_turn_host_ok: got %b want 0", bus32.host_ok); end
      step();
      n_checks += 2;
      if (bus32.host_ok !== 1'b1) begin n_fail++; $display("FAIL preempt_host_ok: got %b want 1", bus32.host_ok); end
      if (bus32.gnt !== 8'h00)    begin n_fail++; $display("FAIL preempt_host_gnt: got %h want 00", bus32.gnt); end
      bus32.host_we = 1'b0;
      step();
      n_checks += 2;
      if (bus32.host_ok !== 1'b0) begin n_fail++; $display("FAIL preempt_turn2_host_ok: got %b want 0", bus32.host_ok); end
      if (bus32.gnt !== 8'h00)    begin n_fail++; $display("FAIL preempt_turn2_gnt: got %h want 00", bus32.gnt); end
      step();
      n_checks += 3;
      if (bus32.gnt !== 8'h08)     begin n_fail++; $display("FAIL preempt_regnt: got %h want 08", bus32.gnt); end
      if (bus32.gnt_id !== 3'd3)   begin n_fail++; $display("FAIL preempt_regnt_id: got %0d want 3", bus32.gnt_id); end
      if (bus32.word_cnt !== 5'd0) begin n_fail++; $display("FAIL preempt_regnt_word_cnt: got %0d want 0", bus32.word_cnt); end
      bus32.req = 8'h00;
      step();
      step();
      n_checks += 1;
      if (bus32.bus_busy !== 1'b0) begin n_fail++; $display("FAIL preempt_idle_busy: got %b want 0", bus32.bus_busy); end
   endtask

   task automatic test_host_first();
      do_reset();
      bus32.host_we = 1'b1;
      bus32.req     = 8'hFF;
      step();
      n_checks += 2;
      if (bus32.host_ok !== 1'b1) begin n_fail++; $display("FAIL first_host_ok: got %b want 1", bus32.host_ok); end
      if (bus32.gnt !== 8'h00)    begin n_fail++; $display("FAIL first_host_gnt: got %h want 00", bus32.gnt); end
      bus32.host_we = 1'b0;
      step();
      n_checks += 1;
      if (bus32.host_ok !== 1'b0) begin n_fail++; $display("FAIL first_turn_host_ok: got %b want 0", bus32.host_ok); end
      step();
      for (int i = 0; i < 8; i++) begin
         n_checks += 2;
         if (bus32.gnt !== (8'(1) << i)) begin n_fail++; $display("FAIL order_gnt pe%0d: got %h want %h", i, bus32.gnt, 8'(1) << i); end
         if (bus32.gnt_id !== 3'(i))     begin n_fail++; $display("FAIL order_gnt_id pe%0d: got %0d want %0d", i, bus32.gnt_id, i); end
         bus32.req[i] = 1'b0;
         step();
         n_checks += 1;
         if (bus32.gnt !== 8'h00) begin n_fail++; $display("FAIL order_turn pe%0d: got %h want 00", i, bus32.gnt); end
         step();
      end
      n_checks += 1;
      if (bus32.bus_busy !== 1'b0) begin n_fail++; $display("FAIL order_idle_busy: got %b want 0", bus32.bus_busy); end
   endtask

   task automatic test_async_reset();
      bus32.req = 8'h20;
      step();
      n_checks += 1;
      if (bus32.gnt !== 8'h20) begin n_fail++; $display("FAIL areset_pre_gnt: got %h want 20", bus32.gnt); end
      bus32.req = 8'h00;
      step();
      step();
      bus32.req = 8'h20;
      step();
      step();
      n_checks += 2;
      if (bus32.gnt !== 8'h20)     begin n_fail++; $display("FAIL areset_hold_gnt: got %h want 20", bus32.gnt); end
      if (bus32.word_cnt !== 5'd1) begin n_fail++; $display("FAIL areset_hold_word_cnt: got %0d want 1", bus32.word_cnt); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks += 5;
      if (bus32.gnt !== 8'h00)     begin n_fail++; $display("FAIL areset_gnt: got %h want 00", bus32.gnt); end
      if (bus32.host_ok !== 1'b0)  begin n_fail++; $display("FAIL areset_host_ok: got %b want 0", bus32.host_ok); end
      if (bus32.bus_busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b want 0", bus32.bus_busy); end
      if (bus32.word_cnt !== 5'd0) begin n_fail++; $display("FAIL areset_word_cnt: got %0d want 0", bus32.word_cnt); end
      if (bus32.gnt_id !== 3'd0)   begin n_fail++; $display("FAIL areset_gnt_id: got %0d want 0", bus32.gnt_id); end
      bus32.req = 8'h21;
      step();
      rst_n = 1'b1;
      step();
      n_checks += 2;
      if (bus32.gnt !== 8'h01)   begin n_fail++; $display("FAIL areset_rr_gnt: got %h want 01", bus32.gnt); end
      if (bus32.gnt_id !== 3'd0) begin n_fail++; $display("FAIL areset_rr_gnt_id: got %0d want 0", bus32.gnt_id); end
      bus32.req = 8'h00;
      step();
      step();
   endtask

   task automatic test_lone_burst();
      bus32.req = 8'h80;
      step();
      n_checks += 2;
      if (bus32.gnt !== 8'h80)     begin n_fail++; $display("FAIL lone_gnt start: got %h want 80", bus32.gnt); end
      if (bus32.word_cnt !== 5'd0) begin n_fail++; $display("FAIL lone_word_cnt start: got %0d want 0", bus32.word_cnt); end
      for (int k = 1; k <= 40; k++) begin
         step();
         n_checks += 2;
         if (bus32.gnt !== 8'h80)            begin n_fail++; $display("FAIL lone_gnt c%0d: got %h want 80", k, bus32.gnt); end
         if (bus32.word_cnt !== 5'(k % 32))  begin n_fail++; $display("FAIL lone_word_cnt c%0d: got %0d want %0d", k, bus32.word_cnt, k % 32); end
      end
      bus32.req = 8'h00;
      step();
      step();
      n_checks += 1;
      if (bus32.bus_busy !== 1'b0) begin n_fail++; $display("FAIL lone_idle_busy: got %b want 0", bus32.bus_busy); end
   endtask

   initial begin
      test_reset();
      test_basic_grant();
      test_burst_rr();
      test_host_preempt();
      test_host_first();
      test_async_reset();
      test_lone_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
